hdr_ddr_word_serializer: RTL and testbench
==========================================

Name: hdr_ddr_word_serializer

Overview:
- Transmit-side serializer for I3C HDR-DDR 20-bit words: 2 preamble bits, 16 data bits, 2 parity bits.
- Sits directly upstream of frame_counter and drives its bit-count input (o_cnt_bit_count).
- Consumes the frame counter's last-frame flag to stop after the final word.
- Takes words over a valid/ready handshake from the HDR engine and shifts one bit per enabled clock onto the SDA driver path.

Parameters:
- DATA_W, 16, data bits per word; fixed by the HDR-DDR protocol, exposed only for package consistency.
- IDLE_SDO, 1'b1, level driven on o_ser_sdo when not shifting.

Ports:
- i_ser_clk  in  1  block clock; one bit period per cycle.
- i_ser_rst  in  1  synchronous reset, active-high.
- i_ser_en  in  1  enable; low aborts any word in flight.
- i_ser_word_valid  in  1  upstream has a word.
- i_ser_preamble  in  2  preamble for the offered word.
- i_ser_data  in  16  data for the offered word.
- i_fcnt_last_frame  in  1  frame counter reports the current word is the last one.
- o_ser_word_ready  out  1  word accepted when valid && ready.
- o_ser_sdo  out  1  serial data out.
- o_cnt_bit_count  out  6  bit index of o_ser_sdo, 0..19; feeds the frame counter.
- o_ser_word_done  out  1  one-cycle pulse on bit 19.
- o_ser_frames_done  out  1  one-cycle pulse when a word ends with last-frame set.
- o_ser_underrun  out  1  high while stalled mid-transfer with no word available.
- o_ser_busy  out  1  high in SHIFT or HOLD.

Behaviour:
- Reset (i_ser_rst high at a clock edge):
  - State becomes IDLE; o_ser_sdo=IDLE_SDO; o_cnt_bit_count=0.
  - Every pulse, flag and busy output is 0.
  - o_ser_word_ready is forced 0 while i_ser_rst is high.
  - Reset mid-word discards the word and generates no pulses.
- States: IDLE, SHIFT, HOLD.
- o_ser_word_ready = i_ser_en && !i_ser_rst && (IDLE || HOLD || (SHIFT && count==19 && !i_fcnt_last_frame)).
- Acceptance:
  - On the accept edge, latch {preamble, data, PA1, PA0} into a 20-bit shift register.
  - PA1 = XOR of D15,D13,...,D1.
  - PA0 = XOR of D14,D12,...,D0, XOR 1.
  - Latency: a word accepted at edge N has bit 0 (preamble[1]) on o_ser_sdo after edge N, with count=0.
- Bit order and timing:
  - Bits are sent MSB first: P1, P0, D15..D0, PA1, PA0.
  - Count increments by 1 per cycle in SHIFT.
  - o_ser_sdo and o_cnt_bit_count are registered and change together.
- Bit 19 cycle:
  - o_ser_word_done=1.
  - If i_fcnt_last_frame=1: pulse o_ser_frames_done, go to IDLE, count→0, sdo→IDLE_SDO.
  - Else if a new word is accepted: next cycle is bit 0 of the new word, with no gap.
  - Else: go to HOLD.
- HOLD:
  - o_ser_underrun=1, sdo=IDLE_SDO, count held at 19.
  - A frame counter keyed on count 19 must not double-decrement; for this reason o_cnt_bit_count is driven 0 while in HOLD.
  - On accept, go to SHIFT at bit 0.
- i_ser_en low in SHIFT or HOLD:
  - Next state is IDLE, count=0, sdo=IDLE_SDO.
  - No word_done or frames_done pulse.
  - i_ser_en low in IDLE: remain in IDLE.
- Simultaneous events: last_frame and valid in the same bit-19 cycle → last_frame wins; ready is 0 and the word is not consumed.
- o_ser_busy = state is SHIFT or HOLD.

Decomposition:
- Shared hdr_ddr_pkg holds:
  - WORD_BITS=20, PRE_W=2, DATA_W=16, PAR_W=2.
  - LAST_BIT=19, MID_BIT=9.
  - The state enum.
  - The parity function.
- One sub-module: hdr_ddr_parity (combinational; 16-bit data in, 2-bit {PA1,PA0} out). It is reused by the receive-side checker.

Test Plan:
- Single word:
  - Stimulus: preamble=2'b10, data=16'hA5A5, last_frame=1 at bit 19.
  - Response: sdo = 1,0, 1010010110100101, 0,1; word_done and frames_done at count 19; IDLE next cycle with sdo=1.
- Parity corners:
  - Stimulus: data 16'h0000, 16'hFFFF, 16'h8000.
  - Response: {PA1,PA0} = 01, 01, 11 respectively.
- Back-to-back:
  - Stimulus: three words, valid held high, last_frame only on the third.
  - Response: 60 contiguous SHIFT cycles; count wraps 19→0 with no gap; word_done pulses 3×.
- Underrun:
  - Stimulus: valid drops after word 1, last_frame=0; valid returns after 5 cycles.
  - Response: HOLD for those cycles with underrun=1, sdo=1, count=0; the next word starts at bit 0 the cycle after accept.
- Abort and reset:
  - Stimulus: i_ser_en low at count 7; separately, i_ser_rst at count 12.
  - Response: IDLE next cycle, sdo=1, count=0, no word_done; ready stays 0 during reset.
- Contention:
  - Stimulus: valid=1 and last_frame=1 in the bit-19 cycle.
  - Response: ready=0, word not consumed, frames_done=1, IDLE follows.

Source files
------------

// File: rtl/hdr_ddr_pkg.sv
// hdr_ddr_pkg: shared HDR-DDR word geometry, serializer states and parity helper
package hdr_ddr_pkg;
  localparam int WORD_BITS = 20;
  localparam int PRE_W = 2;
  localparam int DATA_W = 16;
  localparam int PAR_W = 2;
  localparam int LAST_BIT = 19;
  localparam int MID_BIT = 9;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;
  // {PA1, PA0}: PA1 covers odd data bits, PA0 covers even data bits inverted
  function automatic logic [PAR_W-1:0] ddr_parity(input logic [DATA_W-1:0] d);
    return {^(d & 16'hAAAA), ~^(d & 16'h5555)};
  endfunction
endpackage

// File: rtl/hdr_ddr_parity.sv
// hdr_ddr_parity: combinational HDR-DDR word parity, shared with the receive-side checker
module hdr_ddr_parity
  import hdr_ddr_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [PAR_W-1:0]  par_o
);
  assign par_o = ddr_parity(data_i);
endmodule

// File: rtl/hdr_ddr_word_serializer.sv
// hdr_ddr_word_serializer: shifts 20-bit HDR-DDR words MSB first onto SDO, one bit per cycle
module hdr_ddr_word_serializer #(
  parameter int   DATA_W   = 16,
  parameter logic IDLE_SDO = 1'b1
) (
  input  logic              i_ser_clk,
  input  logic              i_ser_rst,
  input  logic              i_ser_en,
  input  logic              i_ser_word_valid,
  input  logic [1:0]        i_ser_preamble,
  input  logic [DATA_W-1:0] i_ser_data,
  input  logic              i_fcnt_last_frame,
  output logic              o_ser_word_ready,
  output logic              o_ser_sdo,
  output logic [5:0]        o_cnt_bit_count,
  output logic              o_ser_word_done,
  output logic              o_ser_frames_done,
  output logic              o_ser_underrun,
  output logic              o_ser_busy
);
  import hdr_ddr_pkg::*;
  state_e               state_q, state_d;
  logic [WORD_BITS-1:0] sr_q, sr_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [PAR_W-1:0]     par;
  logic                 at_last, accept;
  hdr_ddr_parity u_par (.data_i(i_ser_data), .par_o(par));
  assign at_last = state_q == SHIFT && cnt_q == 6'(LAST_BIT);
  assign o_ser_word_ready = i_ser_en && !i_ser_rst &&
    (state_q == IDLE || state_q == HOLD || (at_last && !i_fcnt_last_frame));
  assign accept = i_ser_word_valid && o_ser_word_ready;
  assign o_ser_word_done = at_last && i_ser_en && !i_ser_rst;
  assign o_ser_frames_done = o_ser_word_done && i_fcnt_last_frame;
  assign o_ser_underrun = state_q == HOLD;
  assign o_ser_busy = state_q != IDLE;
  assign o_ser_sdo = state_q == SHIFT ? sr_q[WORD_BITS-1] : IDLE_SDO;
  // HOLD keeps count at 19 internally but shows 0 so the frame counter does not count twice
  assign o_cnt_bit_count = state_q == SHIFT ? cnt_q : 6'd0;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    if (!i_ser_en) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (accept) begin
      state_d = SHIFT;
      sr_d = {i_ser_preamble, i_ser_data, par};
      cnt_d = '0;
    end else if (at_last) begin
      state_d = i_fcnt_last_frame ? IDLE : HOLD;
      cnt_d = i_fcnt_last_frame ? 6'd0 : cnt_q;
    end else if (state_q == SHIFT) begin
      sr_d = {sr_q[WORD_BITS-2:0], 1'b0};
      cnt_d = cnt_q + 6'd1;
    end
  end
  always_ff @(posedge i_ser_clk) begin
    if (i_ser_rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hdr_ddr_word_serializer.sv
// tb_hdr_ddr_word_serializer: directed checks of the HDR-DDR word serializer
module tb_hdr_ddr_word_serializer;
  logic clk = 1'b0;
  logic rst, en, valid, last;
  logic [1:0] pre;
  logic [15:0] data;
  logic ready, sdo, word_done, frames_done, underrun, busy;
  logic [5:0] cnt;
  int n_cmp = 0;
  int n_err = 0;
  hdr_ddr_word_serializer dut (
    .i_ser_clk(clk), .i_ser_rst(rst), .i_ser_en(en), .i_ser_word_valid(valid),
    .i_ser_preamble(pre), .i_ser_data(data), .i_fcnt_last_frame(last),
    .o_ser_word_ready(ready), .o_ser_sdo(sdo), .o_cnt_bit_count(cnt),
    .o_ser_word_done(word_done), .o_ser_frames_done(frames_done),
    .o_ser_underrun(underrun), .o_ser_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1; en = 1; valid = 1; pre = 2'b10; data = 16'hA5A5; last = 0;
    tick; tick; #1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
    n_cmp++; if (sdo !== 1'b1) begin n_err++; $display("FAIL reset_sdo got %b want 1", sdo); end
    n_cmp++; if (cnt !== 6'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    n_cmp++; if ({busy, word_done, frames_done, underrun} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0000", {busy, word_done, frames_done, underrun}); end
    rst = 0; valid = 0; #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL idle_ready got %b want 1", ready); end
  endtask
  task automatic test_single;
    logic [19:0] w;
    w = {2'b10, 16'hA5A5, 2'b01};
    valid = 1; pre = 2'b10; data = 16'hA5A5; last = 0;
    tick;
    valid = 0; data = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      last = (i == 19); #1;
      n_cmp++; if (sdo !== w[19-i]) begin n_err++; $display("FAIL single_sdo bit %0d got %b want %b", i, sdo, w[19-i]); end
      n_cmp++; if (cnt !== 6'(i)) begin n_err++; $display("FAIL single_cnt got %0d want %0d", cnt, i); end
      n_cmp++; if (word_done !== (i == 19) || frames_done !== (i == 19)) begin n_err++; $display("FAIL single_pulses bit %0d got %b%b want %b", i, word_done, frames_done, {2{i == 19}}); end
      tick;
    end
    last = 0; #1;
    n_cmp++; if ({busy, sdo, cnt} !== {1'b0, 1'b1, 6'd0}) begin n_err++; $display("FAIL single_end got busy=%b sdo=%b cnt=%0d want 0 1 0", busy, sdo, cnt); end
  endtask
  task automatic test_back_to_back;
    logic [1:0] bp[3];
    logic [15:0] bd[3];
    logic [19:0] bw[3];
    int nwd;
    bp = '{2'b10, 2'b01, 2'b10};
    bd = '{16'h0000, 16'hFFFF, 16'h8000};
    bw = '{{2'b10, 16'h0000, 2'b01}, {2'b01, 16'hFFFF, 2'b01}, {2'b10, 16'h8000, 2'b11}};
    nwd = 0;
    valid = 1; pre = bp[0]; data = bd[0]; last = 0;
    tick;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        last = (k == 2 && i == 19);
        if (i == 19 && k < 2) begin pre = bp[k+1]; data = bd[k+1]; end
        #1;
        if (word_done === 1'b1) nwd++;
        n_cmp++; if (sdo !== bw[k][19-i]) begin n_err++; $display("FAIL b2b_sdo word %0d bit %0d got %b want %b", k, i, sdo, bw[k][19-i]); end
        n_cmp++; if (cnt !== 6'(i) || busy !== 1'b1) begin n_err++; $display("FAIL b2b_cnt word %0d got cnt=%0d busy=%b want %0d 1", k, cnt, busy, i); end
        if (i == 19) begin
          n_cmp++; if (ready !== (k < 2)) begin n_err++; $display("FAIL b2b_ready word %0d got %b want %b", k, ready, k < 2); end
          n_cmp++; if (frames_done !== (k == 2)) begin n_err++; $display("FAIL b2b_frames word %0d got %b want %b", k, frames_done, k == 2); end
        end
        tick;
      end
    end
    valid = 0; last = 0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
    n_cmp++; if (nwd !== 3) begin n_err++; $display("FAIL b2b_word_done_count got %0d want 3", nwd); end
  endtask
  task automatic test_underrun;
    logic [19:0] w;
    w = {2'b01, 16'h1234, 2'b00};
    valid = 1; pre = 2'b01; data = 16'h1234; last = 0;
    tick;
    valid = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_cmp++; if (sdo !== w[19-i] || cnt !== 6'(i)) begin n_err++; $display("FAIL under_word1 bit %0d got sdo=%b cnt=%0d want %b %0d", i, sdo, cnt, w[19-i], i); end
      if (i == 19) begin
        n_cmp++; if (word_done !== 1'b1 || frames_done !== 1'b0) begin n_err++; $display("FAIL under_done got %b%b want 10", word_done, frames_done); end
      end
      tick;
    end
    for (int h = 0; h < 5; h++) begin
      #1;
      n_cmp++; if ({underrun, sdo, busy, word_done} !== 4'b1110) begin n_err++; $display("FAIL under_hold cycle %0d got %b want 1110", h, {underrun, sdo, busy, word_done}); end
      n_cmp++; if (cnt !== 6'd0) begin n_err++; $display("FAIL under_hold_cnt got %0d want 0", cnt); end
      tick;
    end
    valid = 1; pre = 2'b10; data = 16'hA5A5; #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL under_ready got %b want 1", ready); end
    tick;
    valid = 0; w = {2'b10, 16'hA5A5, 2'b01};
    for (int i = 0; i < 20; i++) begin
      last = (i == 19); #1;
      n_cmp++; if (sdo !== w[19-i] || cnt !== 6'(i) || underrun !== 1'b0) begin n_err++; $display("FAIL under_word2 bit %0d got sdo=%b cnt=%0d ur=%b want %b %0d 0", i, sdo, cnt, underrun, w[19-i], i); end
      tick;
    end
    last = 0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL under_end got busy=%b want 0", busy); end
  endtask
  task automatic test_abort;
    logic [19:0] w;
    w = {2'b10, 16'hA5A5, 2'b01};
    valid = 1; pre = 2'b10; data = 16'hA5A5; last = 0;
    tick;
    valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) en = 0;
      #1;
      n_cmp++; if (sdo !== w[19-i] || cnt !== 6'(i)) begin n_err++; $display("FAIL abort_shift bit %0d got sdo=%b cnt=%0d want %b %0d", i, sdo, cnt, w[19-i], i); end
      if (i == 7) begin
        n_cmp++; if (ready !== 1'b0 || word_done !== 1'b0) begin n_err++; $display("FAIL abort_en_low got ready=%b wd=%b want 0 0", ready, word_done); end
      end
      tick;
    end
    #1;
    n_cmp++; if ({busy, sdo, cnt, word_done} !== {1'b0, 1'b1, 6'd0, 1'b0}) begin n_err++; $display("FAIL abort_idle got busy=%b sdo=%b cnt=%0d wd=%b want 0 1 0 0", busy, sdo, cnt, word_done); end
    valid = 1; #1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL abort_idle_ready got %b want 0", ready); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_stay_idle got busy=%b want 0", busy); end
    en = 1;
    tick;
    valid = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 12) begin rst = 1; valid = 1; end
      #1;
      n_cmp++; if (cnt !== 6'(i)) begin n_err++; $display("FAIL rstmid_cnt got %0d want %0d", cnt, i); end
      if (i == 12) begin
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready got %b want 0", ready); end
      end
      tick;
    end
    #1;
    n_cmp++; if ({busy, sdo, cnt, ready, word_done} !== {1'b0, 1'b1, 6'd0, 1'b0, 1'b0}) begin n_err++; $display("FAIL rstmid_idle got busy=%b sdo=%b cnt=%0d ready=%b wd=%b want 0 1 0 0 0", busy, sdo, cnt, ready, word_done); end
    tick;
    n_cmp++; if (ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_hold got ready=%b busy=%b want 0 0", ready, busy); end
    rst = 0; valid = 0;
  endtask
  task automatic test_contention;
    logic [19:0] w;
    w = {2'b10, 16'h0000, 2'b01};
    valid = 1; pre = 2'b10; data = 16'h0000; last = 0;
    tick;
    valid = 0;
    for (int i = 0; i < 19; i++) begin
      #1;
      n_cmp++; if (sdo !== w[19-i]) begin n_err++; $display("FAIL cont_sdo bit %0d got %b want %b", i, sdo, w[19-i]); end
      tick;
    end
    last = 1; valid = 1; pre = 2'b01; data = 16'hFFFF; #1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL cont_ready got %b want 0", ready); end
    n_cmp++; if (word_done !== 1'b1 || frames_done !== 1'b1) begin n_err++; $display("FAIL cont_pulses got %b%b want 11", word_done, frames_done); end
    tick;
    last = 0; #1;
    n_cmp++; if ({busy, sdo, ready} !== 3'b011) begin n_err++; $display("FAIL cont_idle got busy/sdo/ready=%b want 011", {busy, sdo, ready}); end
    tick;
    valid = 0; w = {2'b01, 16'hFFFF, 2'b01};
    for (int i = 0; i < 20; i++) begin
      last = (i == 19); #1;
      n_cmp++; if (sdo !== w[19-i] || cnt !== 6'(i)) begin n_err++; $display("FAIL cont_kept_word bit %0d got sdo=%b cnt=%0d want %b %0d", i, sdo, cnt, w[19-i], i); end
      tick;
    end
    last = 0;
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_underrun;
    test_abort;
    test_contention;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
